// File: rtl/uart_fifo_bridge_if.sv
// Byte-stream bundle between the IO controller, the uart core and the FIFO bridge.
// The slave modport is the bridge's view; master is the environment driving it.
interface uart_fifo_bridge_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Handshakes: a byte moves on a rising clk edge where valid && ready are both 1.
    // valid never depends on ready.
    logic [7:0]    tx_din;
    logic          tx_din_valid;
    logic          tx_din_ready;
    logic [7:0]    uart_tx_data;
    logic          uart_tx_valid;
    logic          uart_tx_ready;
    logic [7:0]    uart_rx_data;
    logic          uart_rx_valid;
    logic          uart_rx_ready;
    logic [7:0]    rx_dout;
    logic          rx_dout_valid;
    logic          rx_dout_ready;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;
    logic          rx_overflow;
    logic          clr_overflow;

    modport slave (
        input  tx_din, tx_din_valid, uart_tx_ready, uart_rx_data, uart_rx_valid,
               rx_dout_ready, clr_overflow,
        output tx_din_ready, uart_tx_data, uart_tx_valid, uart_rx_ready, rx_dout,
               rx_dout_valid, tx_count, rx_count, rx_overflow
    );

    modport master (
        output tx_din, tx_din_valid, uart_tx_ready, uart_rx_data, uart_rx_valid,
               rx_dout_ready, clr_overflow,
        input  tx_din_ready, uart_tx_data, uart_tx_valid, uart_rx_ready, rx_dout,
               rx_dout_valid, tx_count, rx_count, rx_overflow
    );
endinterface

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// First-word-fall-through FIFO; full and empty come only from the occupancy count.
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    output logic             o_push_ok,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_pop_ok,
    output logic [WIDTH-1:0] o_dout,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_pop_ok  = i_pop && !o_empty;
    assign o_push_ok = i_push && (!o_full || o_pop_ok);
    assign o_dout    = r_mem[r_rptr];
    assign o_count   = r_count;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (o_push_ok) r_mem[r_wptr] <= i_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (o_push_ok) r_wptr <= r_wptr + 1'b1;
            if (o_pop_ok)  r_rptr <= r_rptr + 1'b1;
            case ({o_push_ok, o_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/uart_fifo_bridge.sv
// TX/RX byte buffering between the IO controller and the uart core.
// RX cannot stall the uart, so bytes arriving into a full FIFO are dropped and flagged.
module uart_fifo_bridge #(
    parameter int DEPTH = 16
) (
    input logic                clk,
    input logic                rst,
    uart_fifo_bridge_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          w_tx_push;
    logic          w_tx_push_ok;
    logic          w_tx_pop_ok;
    logic          w_tx_full;
    logic          w_tx_empty;
    logic [CW-1:0] w_tx_count;

    logic          w_rx_push_ok;
    logic          w_rx_pop;
    logic          w_rx_pop_ok;
    logic          w_rx_full;
    logic          w_rx_empty;
    logic [CW-1:0] w_rx_count;
    logic          w_rx_drop;

    logic          r_rx_overflow;

    // TX refuses a push while full even if the uart drains on the same edge.
    assign w_tx_push = bus.tx_din_valid && !w_tx_full;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_tx_push),
        .o_push_ok (w_tx_push_ok),
        .i_din     (bus.tx_din),
        .i_pop     (bus.uart_tx_ready),
        .o_pop_ok  (w_tx_pop_ok),
        .o_dout    (bus.uart_tx_data),
        .o_count   (w_tx_count),
        .o_full    (w_tx_full),
        .o_empty   (w_tx_empty)
    );

    assign w_rx_pop = bus.rx_dout_ready;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (bus.uart_rx_valid),
        .o_push_ok (w_rx_push_ok),
        .i_din     (bus.uart_rx_data),
        .i_pop     (w_rx_pop),
        .o_pop_ok  (w_rx_pop_ok),
        .o_dout    (bus.rx_dout),
        .o_count   (w_rx_count),
        .o_full    (w_rx_full),
        .o_empty   (w_rx_empty)
    );

    assign w_rx_drop = bus.uart_rx_valid && !w_rx_push_ok;

    // A drop on the same edge as a clear leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   r_rx_overflow <= 1'b0;
        else if (w_rx_drop)        r_rx_overflow <= 1'b1;
        else if (bus.clr_overflow) r_rx_overflow <= 1'b0;
    end

    assign bus.tx_din_ready  = !w_tx_full;
    assign bus.uart_tx_valid = !w_tx_empty;
    assign bus.uart_rx_ready = 1'b1;
    assign bus.rx_dout_valid = !w_rx_empty;
    assign bus.tx_count      = w_tx_count;
    assign bus.rx_count      = w_rx_count;
    assign bus.rx_overflow   = r_rx_overflow;

    logic w_unused_status;
    assign w_unused_status = &{1'b0, w_tx_push_ok, w_tx_pop_ok, w_rx_full, w_rx_pop_ok};
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed and randomized bench for uart_fifo_bridge against a queue-based model.
module tb_uart_fifo_bridge;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_fifo_bridge_if #(.DEPTH(DEPTH)) bus ();

    uart_fifo_bridge #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] tx_sent[$];
    logic [7:0] rx_read[$];
    logic       ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        ovf = 1'b0;
    endtask

    // Compare visible outputs with the model, advance the model by one edge, then step.
    task automatic cycle();
        bit tx_push, tx_pop, rx_push, rx_pop, drop;
        check("tx_din_ready",  bus.tx_din_ready,  32'(tx_q.size() != DEPTH));
        check("uart_tx_valid", bus.uart_tx_valid, 32'(tx_q.size() != 0));
        check("tx_count",      bus.tx_count,      tx_q.size());
        check("rx_dout_valid", bus.rx_dout_valid, 32'(rx_q.size() != 0));
        check("rx_count",      bus.rx_count,      rx_q.size());
        check("rx_overflow",   bus.rx_overflow,   ovf);
        check("uart_rx_ready", bus.uart_rx_ready, 1);
        if (tx_q.size() != 0) check("uart_tx_data", bus.uart_tx_data, tx_q[0]);
        if (rx_q.size() != 0) check("rx_dout", bus.rx_dout, rx_q[0]);

        tx_push = bus.tx_din_valid && (tx_q.size() < DEPTH);
        tx_pop  = bus.uart_tx_ready && (tx_q.size() > 0);
        rx_pop  = bus.rx_dout_ready && (rx_q.size() > 0);
        rx_push = bus.uart_rx_valid && ((rx_q.size() < DEPTH) || rx_pop);
        drop    = bus.uart_rx_valid && !rx_push;
        if (tx_pop)  tx_sent.push_back(tx_q.pop_front());
        if (tx_push) tx_q.push_back(bus.tx_din);
        if (rx_pop)  rx_read.push_back(rx_q.pop_front());
        if (rx_push) rx_q.push_back(bus.uart_rx_data);
        if (drop)                  ovf = 1'b1;
        else if (bus.clr_overflow) ovf = 1'b0;

        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.tx_din        = 8'h00;
        bus.tx_din_valid  = 1'b0;
        bus.uart_tx_ready = 1'b0;
        bus.uart_rx_data  = 8'h00;
        bus.uart_rx_valid = 1'b0;
        bus.rx_dout_ready = 1'b0;
        bus.clr_overflow  = 1'b0;
    endtask

    task automatic check_empty_ready(input string tag);
        check({tag, "_tx_din_ready"},  bus.tx_din_ready,  1);
        check({tag, "_uart_tx_valid"}, bus.uart_tx_valid, 0);
        check({tag, "_rx_dout_valid"}, bus.rx_dout_valid, 0);
        check({tag, "_uart_rx_ready"}, bus.uart_rx_ready, 1);
        check({tag, "_tx_count"},      bus.tx_count,      0);
        check({tag, "_rx_count"},      bus.rx_count,      0);
        check({tag, "_rx_overflow"},   bus.rx_overflow,   0);
    endtask

    initial begin
        // Reset and idle
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_empty_ready("reset");
        rst = 1'b0;
        repeat (2) cycle();

        // TX burst into a stalled uart: 17 offers, only 16 accepted
        bus.tx_din_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.tx_din = 8'(8'h41 + i);
            cycle();
        end
        bus.tx_din_valid = 1'b0;
        check("burst_tx_count_full", bus.tx_count, 16);
        check("burst_tx_din_ready",  bus.tx_din_ready, 0);
        tx_sent.delete();
        bus.uart_tx_ready = 1'b1;
        repeat (17) cycle();
        check("burst_drain_len", tx_sent.size(), 16);
        for (int i = 0; i < 16 && i < tx_sent.size(); i++)
            check($sformatf("burst_byte%0d", i), tx_sent[i], 8'(8'h41 + i));
        check("burst_tx_count_empty", bus.tx_count, 0);

        // TX full with simultaneous offer and drain
        bus.uart_tx_ready = 1'b0;
        bus.tx_din_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.tx_din = 8'(8'h60 + i);
            cycle();
        end
        bus.tx_din        = 8'h99;
        bus.uart_tx_ready = 1'b1;
        cycle();
        check("full_push_refused_count", bus.tx_count, 15);
        bus.tx_din = 8'h9A;
        cycle();
        check("push_pop_count_held", bus.tx_count, 15);
        bus.tx_din_valid = 1'b0;
        repeat (16) cycle();
        check("full_drain_count", bus.tx_count, 0);
        bus.uart_tx_ready = 1'b0;

        // RX overflow: 17 bytes into a FIFO nobody reads
        bus.uart_rx_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.uart_rx_data = 8'(i);
            cycle();
        end
        bus.uart_rx_valid = 1'b0;
        check("ovf_rx_count", bus.rx_count, 16);
        check("ovf_flag_set", bus.rx_overflow, 1);
        bus.clr_overflow = 1'b1;
        cycle();
        bus.clr_overflow = 1'b0;
        check("ovf_flag_cleared", bus.rx_overflow, 0);

        // RX full with simultaneous pop: 0xAA must be kept
        rx_read.delete();
        bus.rx_dout_ready = 1'b1;
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = 8'hAA;
        cycle();
        bus.uart_rx_valid = 1'b0;
        bus.rx_dout_ready = 1'b0;
        check("rx_pushpop_count", bus.rx_count, 16);
        check("rx_pushpop_no_ovf", bus.rx_overflow, 0);
        bus.rx_dout_ready = 1'b1;
        repeat (17) cycle();
        bus.rx_dout_ready = 1'b0;
        check("rx_read_len", rx_read.size(), 17);
        for (int i = 0; i < 16 && i < rx_read.size(); i++)
            check($sformatf("rx_byte%0d", i), rx_read[i], 8'(i));
        if (rx_read.size() == 17) check("rx_last_aa", rx_read[16], 8'hAA);

        // Reset mid-burst with 5 bytes in each FIFO
        bus.tx_din_valid  = 1'b1;
        bus.uart_rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.tx_din       = 8'(8'hC0 + i);
            bus.uart_rx_data = 8'(8'hD0 + i);
            cycle();
        end
        check("pre_rst_tx_count", bus.tx_count, 5);
        check("pre_rst_rx_count", bus.rx_count, 5);
        #2;
        rst = 1'b1;
        #1;
        check_empty_ready("async_rst");
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.uart_tx_ready = 1'b1;
        bus.rx_dout_ready = 1'b1;
        repeat (4) cycle();
        check("post_rst_tx_valid", bus.uart_tx_valid, 0);
        check("post_rst_rx_valid", bus.rx_dout_valid, 0);

        // Randomized traffic with varying back-pressure
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i < 300) ? 1 : 3;
            bus.tx_din        = 8'($urandom_range(0, 255));
            bus.tx_din_valid  = ($urandom_range(0, 3) != 0);
            bus.uart_tx_ready = ($urandom_range(0, 3) < bias);
            bus.uart_rx_data  = 8'($urandom_range(0, 255));
            bus.uart_rx_valid = ($urandom_range(0, 3) != 0);
            bus.rx_dout_ready = ($urandom_range(0, 3) < bias);
            bus.clr_overflow  = ($urandom_range(0, 15) == 0);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
- Byte-buffering stage between the memory-mapped IO controller and the uart core.
- TX direction: absorbs CPU byte writes into a FIFO and drains them to the uart transmitter at line rate.
- RX direction: captures every byte the uart receiver presents and holds it until the CPU reads it. Bytes that arrive while the RX FIFO is full are dropped, and a sticky overflow flag is raised.
- The IO controller sees the same valid/ready byte interface it uses toward the uart, plus FIFO occupancy and status.

Parameters:
- DEPTH, 16, entries per FIFO; power of two, at least 2.
- CW, $clog2(DEPTH)+1, width of the occupancy counts (derived localparam, not overridable).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tx_din  in  8  byte from the IO controller.
- tx_din_valid  in  1  tx_din is offered.
- tx_din_ready  out  1  TX FIFO can accept a byte.
- uart_tx_data  out  8  head of the TX FIFO, to the uart data_in.
- uart_tx_valid  out  1  TX FIFO is non-empty.
- uart_tx_ready  in  1  uart data_in_ready.
- uart_rx_data  in  8  uart data_out.
- uart_rx_valid  in  1  uart data_out_valid.
- uart_rx_ready  out  1  to uart data_out_ready.
- rx_dout  out  8  head of the RX FIFO.
- rx_dout_valid  out  1  RX FIFO is non-empty.
- rx_dout_ready  in  1  IO controller consumes the head byte.
- tx_count  out  CW  TX FIFO occupancy.
- rx_count  out  CW  RX FIFO occupancy.
- rx_overflow  out  1  sticky: an RX byte was dropped.
- clr_overflow  in  1  clears rx_overflow.

Behaviour:
- Reset (asynchronous, active-high):
  - Pointers and counts go to 0; rx_overflow goes to 0.
  - tx_din_ready is 1 and uart_tx_valid is 0.
  - rx_dout_valid is 0 and uart_rx_ready is 1.
  - FIFO storage contents are not reset.
  - Reset asserted mid-transfer discards all buffered bytes; no partial state survives.
- Both FIFOs are first-word-fall-through:
  - Data is written into the array on the push clock edge.
  - The head entry appears on the output in the cycle after the push, with valid high.
  - Latency from push to visible output is 1 cycle.
- Transfer rule: a transfer occurs on a rising clk edge where valid && ready. A pop advances the head on that edge.
- TX FIFO:
  - tx_din_ready = (tx_count != DEPTH).
  - uart_tx_valid = (tx_count != 0).
  - Push and pop in the same cycle leave the count unchanged.
  - When full, a push is refused via ready, even if a pop occurs in that cycle.
  - tx_din is ignored whenever tx_din_ready is 0.
- RX FIFO:
  - uart_rx_ready is constant 1 outside reset, because the uart receiver cannot be stalled.
  - A byte with uart_rx_valid=1 is pushed if rx_count != DEPTH.
  - A byte is also pushed if the RX FIFO is full but rx_dout_valid && rx_dout_ready in the same cycle; this is a simultaneous pop, count unchanged, no overflow.
  - Otherwise the byte is dropped and rx_overflow is set on that edge.
  - rx_dout_valid = (rx_count != 0).
- Overflow flag:
  - clr_overflow clears rx_overflow on the next edge.
  - If a drop and clr_overflow occur in the same cycle, the set wins.
- Pointers:
  - Width log2(DEPTH); they wrap naturally from DEPTH-1 to 0.
  - Full and empty are distinguished solely by the count.
- Counts are always in the range 0..DEPTH; they never underflow or overflow.
- Outputs are driven directly from registers or register-derived compares. There is no combinational path from any *_ready input to any *_valid output.

Decomposition:
- No shared package. DEPTH and CW are module parameters, with CW computed via $clog2.
- One sub-module, sync_fifo (parameters DEPTH, WIDTH=8), instantiated twice:
  - Interface: push/push_ok, pop/pop_ok, head data, count, full, empty.
  - The bridge adds the RX drop/overflow logic and the ready/valid mapping.

Test Plan:
- Reset, then idle: tx_din_ready=1, uart_tx_valid=0, rx_dout_valid=0, tx_count=rx_count=0, rx_overflow=0, uart_rx_ready=1.
- TX burst with uart_tx_ready held 0: push 0x41,0x42,... for 17 cycles with DEPTH=16.
  - tx_count reaches 16 and tx_din_ready drops to 0; the 17th byte is not accepted.
  - Then raise uart_tx_ready: bytes emerge 0x41..0x50 in order, one per cycle, and tx_count returns to 0.
- TX full with simultaneous offer and drain: a push is refused while full; on the next cycle (count 15) a push and a pop together keep the count at 15.
- RX overflow: inject 17 bytes 0x00..0x10 with rx_dout_ready=0.
  - rx_count=16 and rx_overflow=1; the reads yield 0x00..0x0F, and 0x10 is lost.
  - Pulse clr_overflow: rx_overflow=0 on the next cycle.
- RX full with simultaneous pop: with the FIFO full, assert rx_dout_ready and inject 0xAA in the same cycle. rx_count stays 16, no overflow, and 0xAA is read last.
- Reset mid-burst: with 5 bytes in each FIFO, assert rst asynchronously between edges. Outputs immediately show empty and ready; after release, no stale bytes appear.
